// File: rtl/robertson_pkg.sv
// Shared state encoding and sizing helpers for the Robertson multiplier controller.
package robertson_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_INIT  = 3'd1;
    localparam state_t S_ADD   = 3'd2;
    localparam state_t S_SHIFT = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Counter width for 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Multiplier bit index counter: synchronous restart, saturating increment, terminal flag.
module bit_counter
    import robertson_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = cnt_w(N)
) (
    input  logic clk,
    input  logic clear,
    input  logic init,
    input  logic inc,
    output logic last
);

    logic [W-1:0] cnt_q;

    assign last = (cnt_q == W'(N - 1));

    // Increment is gated by last so the index can never wrap past N-1.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (init) begin
            cnt_q <= '0;
        end else if (inc && !last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/robertson_ctrl.sv
// Sequencer for the Robertson signed shift-and-add multiplier datapath.
// Define ROBCTRL_SKIP_ZERO_EN to fold the shift of a zero multiplier bit into its ADD cycle.
module robertson_ctrl
    import robertson_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic q0,
    output logic busy,
    output logic done,
    output logic ld_m,
    output logic sel_init,
    output logic loadh,
    output logic loadl,
    output logic sub,
    output logic shift,
    output logic f_clr,
    output logic f_upd
);

    localparam int unsigned W = cnt_w(N);

    state_t state_q, state_d;
    logic   last;
    logic   cnt_init;
    logic   cnt_inc;

    bit_counter #(
        .N (N),
        .W (W)
    ) u_bit_counter (
        .clk   (clk),
        .clear (clear),
        .init  (cnt_init),
        .inc   (cnt_inc),
        .last  (last)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        ld_m     = 1'b0;
        sel_init = 1'b0;
        loadh    = 1'b0;
        loadl    = 1'b0;
        sub      = 1'b0;
        shift    = 1'b0;
        f_clr    = 1'b0;
        f_upd    = 1'b0;
        cnt_init = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                busy     = 1'b1;
                ld_m     = 1'b1;
                sel_init = 1'b1;
                loadh    = 1'b1;
                loadl    = 1'b1;
                f_clr    = 1'b1;
                cnt_init = 1'b1;
                state_d  = S_ADD;
            end
            S_ADD: begin
                busy = 1'b1;
                if (q0) begin
                    // The final bit carries negative weight in two's complement.
                    loadh   = 1'b1;
                    f_upd   = 1'b1;
                    sub     = last;
                    state_d = S_SHIFT;
                end else begin
`ifdef ROBCTRL_SKIP_ZERO_EN
                    shift   = 1'b1;
                    loadh   = 1'b1;
                    loadl   = 1'b1;
                    cnt_inc = !last;
                    state_d = last ? S_DONE : S_ADD;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                shift   = 1'b1;
                loadh   = 1'b1;
                loadl   = 1'b1;
                cnt_inc = !last;
                state_d = last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_robertson_ctrl.sv
// Directed bench: drives robertson_ctrl against a small Robertson datapath model.
module tb_robertson_ctrl;

`ifdef ROBCTRL_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic clear;
    logic start;
    logic q0;
    logic busy, done, ld_m, sel_init, loadh, loadl, sub, shift, f_clr, f_upd;

    int passed = 0;
    int total  = 0;

    robertson_ctrl #(
        .N (8)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .q0       (q0),
        .busy     (busy),
        .done     (done),
        .ld_m     (ld_m),
        .sel_init (sel_init),
        .loadh    (loadh),
        .loadl    (loadl),
        .sub      (sub),
        .shift    (shift),
        .f_clr    (f_clr),
        .f_upd    (f_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: hi is {F, A}; F holds the sign of the extended accumulator.
    logic [7:0] mcand, mplier, m_reg;
    logic [8:0] hi;
    logic [7:0] lo;

    assign q0 = lo[0];

    always @(posedge clk) begin
        if (ld_m) m_reg <= mcand;
        if (sel_init) begin
            hi <= '0;
            lo <= mplier;
        end else if (shift) begin
            {hi, lo} <= {hi[8], hi, lo[7:1]};
        end else if (loadh) begin
            hi <= sub ? hi - {m_reg[7], m_reg} : hi + {m_reg[7], m_reg};
        end
    end

    function automatic logic [9:0] outs();
        return {busy, done, ld_m, sel_init, loadh, loadl, sub, shift, f_clr, f_upd};
    endfunction

    task automatic test_reset;
        clear = 1'b1;
        start = 1'b0;
        mcand = '0;
        mplier = '0;
        #3;
        total++;
        if (outs() !== 10'd0) $display("FAIL reset_outputs got=%b want=%b", outs(), 10'd0);
        else passed++;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== 10'd0) $display("FAIL idle_outputs got=%b want=%b", outs(), 10'd0);
        else passed++;
    endtask

    task automatic run_mul(input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] exp_p,
                           input int lat_fix, input int lat_skip, input int exp_sub,
                           input int exp_fupd, input int pulse_at, input string name);
        int lat;
        int cyc;
        int nsub;
        int nfupd;
        bit stray;
        lat   = SKIP ? lat_skip : lat_fix;
        nsub  = 0;
        nfupd = 0;
        stray = 1'b0;
        mcand = mc;
        mplier = mp;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (sub) nsub++;
            if (f_upd) nfupd++;
            start = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (cyc !== lat) $display("FAIL %s_latency got=%0d want=%0d", name, cyc, lat);
        else passed++;
        total++;
        if ({hi[7:0], lo} !== exp_p)
            $display("FAIL %s_product got=%h want=%h", name, {hi[7:0], lo}, exp_p);
        else passed++;
        total++;
        if (nsub !== exp_sub) $display("FAIL %s_sub_count got=%0d want=%0d", name, nsub, exp_sub);
        else passed++;
        total++;
        if (nfupd !== exp_fupd)
            $display("FAIL %s_fupd_count got=%0d want=%0d", name, nfupd, exp_fupd);
        else passed++;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) $display("FAIL %s_idle_after got=%b want=0", name, stray);
        else passed++;
    endtask

    task automatic test_multiply;
        run_mul(8'd5, 8'd3, 16'd15, 18, 12, 0, 2, 0, "mul_5x3");
        run_mul(8'hFB, 8'd3, 16'hFFF1, 18, 12, 0, 2, 0, "mul_m5x3");
        run_mul(8'd3, 8'hFB, 16'hFFF1, 18, 17, 1, 7, 0, "mul_3xm5");
        run_mul(8'h80, 8'h80, 16'h4000, 18, 11, 1, 1, 0, "mul_m128xm128");
    endtask

    task automatic test_start_ignored;
        run_mul(8'd5, 8'd0, 16'd0, 18, 10, 0, 0, 4, "zero_mult_pulse");
    endtask

    task automatic test_clear_abort;
        int cyc;
        int ndone;
        mcand = 8'd7;
        mplier = 8'd7;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (busy !== 1'b1) $display("FAIL abort_busy_before got=%b want=1", busy);
        else passed++;
        clear = 1'b1;
        #1;
        total++;
        if (outs() !== 10'd0) $display("FAIL abort_outputs got=%b want=%b", outs(), 10'd0);
        else passed++;
        @(negedge clk);
        clear = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        total++;
        if (ndone !== 0) $display("FAIL abort_no_done got=%0d want=0", ndone);
        else passed++;
        run_mul(8'd7, 8'd7, 16'd49, 18, 13, 0, 3, 0, "mul_7x7");
    endtask

    task automatic test_back_to_back;
        int lat;
        int cyc;
        lat = SKIP ? 12 : 18;
        mcand = 8'd5;
        mplier = 8'd3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== lat) $display("FAIL b2b_first_done got=%0d want=%0d", cyc, lat);
        else passed++;
        @(negedge clk);
        cyc++;
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL b2b_gap_idle got=%b want=00", {busy, done});
        else passed++;
        @(negedge clk);
        cyc++;
        total++;
        if ({busy, ld_m} !== 2'b11) $display("FAIL b2b_second_init got=%b want=11", {busy, ld_m});
        else passed++;
        while (!done && cyc < 120) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (cyc !== 2 * lat + 1) $display("FAIL b2b_second_done got=%0d want=%0d", cyc, 2 * lat + 1);
        else passed++;
        total++;
        if ({hi[7:0], lo} !== 16'd15)
            $display("FAIL b2b_product got=%h want=%h", {hi[7:0], lo}, 16'd15);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_final_idle got=%b want=0", busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_start_ignored();
        test_clear_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
